imem_loader: RTL and testbench

- Write-side counterpart of the instruction memory: accepts a little-endian byte stream over a valid/ready handshake and packs it into 32-bit instruction words.
- Writes each word into a RAM-based instruction memory, which the RV32I single-cycle core then fetches from.
- Holds the CPU in reset (cpu_hold) until a complete, valid image has been written.
- Sits between a host byte source (UART RX or testbench) and the instruction-memory write port.

---
 rtl/imem_loader_pkg.sv | 36 +++
 rtl/imem_loader_if.sv | 32 +++
 rtl/byte_word_packer.sv | 66 ++++++
 rtl/imem_loader.sv | 159 +++++++++++++++
 tb/tb_imem_loader.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared types and constants for the instruction-memory image loader.
//   state_e        : loader FSM states
//   HDR_BYTES      : length of the little-endian word-count header
//   BYTES_PER_WORD : bytes packed into one instruction word
//   csum_t         : 8-bit modulo-256 running checksum
//   is_accepting() : true in the states that take bytes from the host
//   is_startable() : true in the states where a start pulse is honoured
// -----------------------------------------------------------------------------
package imem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR0,
      HDR1,
      DATA,
      CSUM,
      DONE,
      ERR
   } state_e;

   localparam int HDR_BYTES      = 2;
   localparam int BYTES_PER_WORD = 4;

   typedef logic [7:0] csum_t;

   function automatic logic is_accepting(input state_e s);
      return (s == HDR0) || (s == HDR1) || (s == DATA) || (s == CSUM);
   endfunction

   function automatic logic is_startable(input state_e s);
      return (s == IDLE) || (s == DONE) || (s == ERR);
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
// Bundles the host byte stream, the instruction-memory write port and the
// loader status lines.
//   master : the loader (takes start/byte stream, drives write port + status)
//   slave  : the host / memory side (the mirror image)
// -----------------------------------------------------------------------------
interface imem_loader_if;

   logic        start;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic        busy;
   logic        done;
   logic        err;
   logic        cpu_hold;

   modport master (
      input  start, byte_valid, byte_data,
      output byte_ready, wr_en, wr_addr, wr_data, busy, done, err, cpu_hold
   );

   modport slave (
      output start, byte_valid, byte_data,
      input  byte_ready, wr_en, wr_addr, wr_data, busy, done, err, cpu_hold
   );

endinterface

// File: rtl/byte_word_packer.sv
// -----------------------------------------------------------------------------
// byte_word_packer
// Shifts incoming bytes into a 32-bit word, first byte ending up in [7:0]
// (little-endian). A 2-bit lane counter tracks the position in the word.
//   clk, reset   : clock, asynchronous active-high reset
//   clr_i        : synchronous clear at the start of a new load
//   byte_en_i    : a data byte is being accepted this cycle
//   byte_i       : the byte
//   word_full_o  : registered one-cycle pulse, the cycle after the 4th byte
//   lane_last_o  : the next accepted byte completes the word
//   word_o       : packed word (complete while word_full_o is high)
// -----------------------------------------------------------------------------
module byte_word_packer
   import imem_loader_pkg::*;
(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        clr_i,
   input  logic                        byte_en_i,
   input  logic [7:0]                  byte_i,
   output logic                        word_full_o,
   output logic                        lane_last_o,
   output logic [8*BYTES_PER_WORD-1:0] word_o
);

   localparam int LANE_W = $clog2(BYTES_PER_WORD);

   logic [LANE_W-1:0]           lane_q;
   logic [8*BYTES_PER_WORD-1:0] word_q;
   logic [8*BYTES_PER_WORD-1:0] word_d;
   logic                        word_full_q;

   // Each lane takes the byte of the lane above; the new byte enters at the top,
   // so after four shifts the first byte sits in the lowest lane.
   genvar gi;
   generate
      for (gi = 0; gi < BYTES_PER_WORD - 1; gi++) begin : g_shift
         assign word_d[8*gi +: 8] = word_q[8*(gi+1) +: 8];
      end
   endgenerate
   assign word_d[8*(BYTES_PER_WORD-1) +: 8] = byte_i;

   assign lane_last_o = (lane_q == LANE_W'(BYTES_PER_WORD - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lane_q      <= '0;
         word_q      <= '0;
         word_full_q <= 1'b0;
      end else begin
         word_full_q <= 1'b0;
         if (clr_i) begin
            lane_q <= '0;
            word_q <= '0;
         end else if (byte_en_i) begin
            word_q      <= word_d;
            lane_q      <= lane_q + 1'b1;
            word_full_q <= lane_last_o;
         end
      end
   end

   assign word_full_o = word_full_q;
   assign word_o      = word_q;

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Receives a little-endian byte image (2-byte word count N, then N words),
// packs it into 32-bit words, writes them to instruction memory and keeps the
// CPU in reset until the whole image has arrived.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : imem_loader_if.master (start, byte stream, write port, status)
// Parameters: DEPTH (largest legal image, in words), CNT_W (header width).
// Build option: define IMEM_LOADER_CHECKSUM_EN to require a trailing checksum
// byte making the modulo-256 sum of every image byte zero.
// -----------------------------------------------------------------------------
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int CNT_W = 16
) (
   input  logic          clk,
   input  logic          reset,
   imem_loader_if.master bus
);

   // State entered once the body (or an empty header) has been consumed.
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_e BODY_END = CSUM;
`else
   localparam state_e BODY_END = DONE;
`endif

   state_e                 state_q, state_d;
   logic                   byte_ready_q, busy_q, done_q, err_q, cpu_hold_q;
   logic [7:0]             n_lo_q;
   logic [CNT_W-1:0]       n_q;
   logic [CNT_W-1:0]       word_idx_q;
   logic [31:0]            wr_addr_q;

   logic                   accept;
   logic                   start_ok;
   logic                   lane_last;
   logic                   word_full;
   logic                   last_word;
   logic [8*HDR_BYTES-1:0] hdr_n;
   logic [CNT_W-1:0]       n_hdr;
   logic [31:0]            word;

   assign accept    = bus.byte_valid && byte_ready_q;
   assign start_ok  = bus.start && is_startable(state_q);
   assign hdr_n     = {bus.byte_data, n_lo_q};
   assign n_hdr     = CNT_W'(hdr_n);
   assign last_word = (word_idx_q == n_q - CNT_W'(1));

   byte_word_packer u_packer (
      .clk         (clk),
      .reset       (reset),
      .clr_i       (start_ok),
      .byte_en_i   (accept && (state_q == DATA)),
      .byte_i      (bus.byte_data),
      .word_full_o (word_full),
      .lane_last_o (lane_last),
      .word_o      (word)
   );

`ifdef IMEM_LOADER_CHECKSUM_EN
   csum_t csum_q;
   csum_t csum_sum;

   // Includes the byte being accepted, so in CSUM this is the final total.
   assign csum_sum = csum_q + bus.byte_data;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         csum_q <= '0;
      end else if (start_ok) begin
         csum_q <= '0;
      end else if (accept) begin
         csum_q <= csum_sum;
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE, ERR: begin
            if (bus.start) state_d = HDR0;
         end
         HDR0: begin
            if (accept) state_d = HDR1;
         end
         HDR1: begin
            if (accept) begin
               if (n_hdr == '0)                    state_d = BODY_END;
               else if (n_hdr > CNT_W'(DEPTH))     state_d = ERR;
               else                                state_d = DATA;
            end
         end
         DATA: begin
            // Words complete in order, so word_idx_q is the index of the word
            // this byte finishes (the previous word's write is long retired).
            if (accept && lane_last && last_word) state_d = BODY_END;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         CSUM: begin
            if (accept) state_d = (csum_sum == '0) ? DONE : ERR;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         byte_ready_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         cpu_hold_q   <= 1'b1;
         n_lo_q       <= '0;
         n_q          <= '0;
         word_idx_q   <= '0;
         wr_addr_q    <= '0;
      end else begin
         state_q      <= state_d;
         // Status flags are decoded from the next state so they stay aligned
         // with state_q while remaining plain registers.
         byte_ready_q <= is_accepting(state_d);
         busy_q       <= is_accepting(state_d);
         done_q       <= (state_d == DONE);
         err_q        <= (state_d == ERR);
         cpu_hold_q   <= (state_d != DONE);

         if (start_ok) begin
            n_lo_q     <= '0;
            n_q        <= '0;
            word_idx_q <= '0;
            wr_addr_q  <= '0;
         end else begin
            if (accept && (state_q == HDR0)) n_lo_q <= bus.byte_data;
            if (accept && (state_q == HDR1)) n_q    <= n_hdr;
            // Advance only after the write cycle has presented the address.
            if (word_full) begin
               word_idx_q <= word_idx_q + 1'b1;
               wr_addr_q  <= wr_addr_q + 32'd4;
            end
         end
      end
   end

   assign bus.byte_ready = byte_ready_q;
   assign bus.wr_en      = word_full;
   assign bus.wr_addr    = wr_addr_q;
   assign bus.wr_data    = word;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.err        = err_q;
   assign bus.cpu_hold   = cpu_hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Directed bench for imem_loader. Inputs change on the falling edge; outputs
// are sampled on the falling edge. A monitor records every write strobe.
// -----------------------------------------------------------------------------
module tb_imem_loader;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   imem_loader_if bus ();

   imem_loader #(.DEPTH(16), .CNT_W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // Nominal image: N=2, words 0x00110233 and 0x401102B3.
   logic [7:0] img [10] = '{8'h02, 8'h00, 8'h33, 8'h02, 8'h11, 8'h00,
                            8'hB3, 8'h02, 8'h11, 8'h40};
   // Byte sum of img is 0x4E, so 0xB2 brings the total to 0x00.
   logic [7:0] good_csum = 8'hB2;

   logic [31:0] wa [$];
   logic [31:0] wd [$];
   int          hold_bad;
   int          dbl_wr;
   logic        prev_wr = 1'b0;

   always @(negedge clk) begin
      if (bus.wr_en) begin
         wa.push_back(bus.wr_addr);
         wd.push_back(bus.wr_data);
         $display("write addr=%h data=%h", bus.wr_addr, bus.wr_data);
      end
      if (bus.wr_en && prev_wr) dbl_wr++;
      prev_wr = bus.wr_en;
      if (bus.busy && !bus.cpu_hold) hold_bad++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   task automatic clear_mon();
      wa.delete();
      wd.delete();
      hold_bad = 0;
      dbl_wr   = 0;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      bus.byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
      bus.byte_valid = 1'b1;
      bus.byte_data  = b;
      t = 0;
      while (!bus.byte_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!bus.byte_ready) begin
         checks++;
         errors++;
         $display("FAIL send_byte: byte_ready=%b after 50 cycles, required 1", bus.byte_ready);
      end
      @(negedge clk);
      bus.byte_valid = 1'b0;
      $display("byte %h sent", b);
   endtask

   task automatic send_image(input int gmax);
      for (int i = 0; i < 10; i++) send_byte(img[i], $urandom_range(0, gmax));
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(good_csum, $urandom_range(0, gmax));
`endif
   endtask

   task automatic check_two_words(input string tag);
      checks++; if (wa.size() !== 2) begin errors++; $display("FAIL %s write_count: got %0d required 2", tag, wa.size()); end
      if (wa.size() >= 2) begin
         checks++; if (wa[0] !== 32'h0) begin errors++; $display("FAIL %s addr0: got %h required 00000000", tag, wa[0]); end
         checks++; if (wd[0] !== 32'h00110233) begin errors++; $display("FAIL %s data0: got %h required 00110233", tag, wd[0]); end
         checks++; if (wa[1] !== 32'h4) begin errors++; $display("FAIL %s addr1: got %h required 00000004", tag, wa[1]); end
         checks++; if (wd[1] !== 32'h401102B3) begin errors++; $display("FAIL %s data1: got %h required 401102b3", tag, wd[1]); end
      end
   endtask

   task automatic test_reset();
      checks++; if (bus.byte_ready !== 1'b0) begin errors++; $display("FAIL reset byte_ready: got %b required 0", bus.byte_ready); end
      checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL reset wr_en: got %b required 0", bus.wr_en); end
      checks++; if (bus.wr_addr !== 32'h0) begin errors++; $display("FAIL reset wr_addr: got %h required 0", bus.wr_addr); end
      checks++; if (bus.wr_data !== 32'h0) begin errors++; $display("FAIL reset wr_data: got %h required 0", bus.wr_data); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b required 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset done: got %b required 0", bus.done); end
      checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset err: got %b required 0", bus.err); end
      checks++; if (bus.cpu_hold !== 1'b1) begin errors++; $display("FAIL reset cpu_hold: got %b required 1", bus.cpu_hold); end
   endtask

   task automatic test_nominal();
      clear_mon();
      pulse_start();
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL nominal busy_after_start: got %b required 1", bus.busy); end
      checks++; if (bus.byte_ready !== 1'b1) begin errors++; $display("FAIL nominal ready_after_start: got %b required 1", bus.byte_ready); end
      send_image(0);
      repeat (3) @(negedge clk);
      check_two_words("nominal");
      checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL nominal done: got %b required 1", bus.done); end
      checks++; if (bus.cpu_hold !== 1'b0) begin errors++; $display("FAIL nominal cpu_hold: got %b required 0", bus.cpu_hold); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL nominal busy: got %b required 0", bus.busy); end
      checks++; if (bus.byte_ready !== 1'b0) begin errors++; $display("FAIL nominal byte_ready: got %b required 0", bus.byte_ready); end
      checks++; if (hold_bad !== 0) begin errors++; $display("FAIL nominal hold_during_load: got %0d low cycles required 0", hold_bad); end
      checks++; if (dbl_wr !== 0) begin errors++; $display("FAIL nominal back_to_back_wr: got %0d required 0", dbl_wr); end
   endtask

   task automatic test_oversize();
      clear_mon();
      pulse_start();
      send_byte(8'h11, 0);
      send_byte(8'h00, 0);
      // Bytes offered while in ERR must be ignored.
      bus.byte_valid = 1'b1;
      bus.byte_data  = 8'hAA;
      repeat (6) @(negedge clk);
      bus.byte_valid = 1'b0;
      checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL oversize err: got %b required 1", bus.err); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL oversize done: got %b required 0", bus.done); end
      checks++; if (bus.cpu_hold !== 1'b1) begin errors++; $display("FAIL oversize cpu_hold: got %b required 1", bus.cpu_hold); end
      checks++; if (bus.byte_ready !== 1'b0) begin errors++; $display("FAIL oversize byte_ready: got %b required 0", bus.byte_ready); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL oversize busy: got %b required 0", bus.busy); end
      checks++; if (wa.size() !== 0) begin errors++; $display("FAIL oversize write_count: got %0d required 0", wa.size()); end
   endtask

   task automatic test_gapped();
      clear_mon();
      pulse_start();
      send_image(3);
      repeat (3) @(negedge clk);
      check_two_words("gapped");
      checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL gapped done: got %b required 1", bus.done); end
      checks++; if (dbl_wr !== 0) begin errors++; $display("FAIL gapped back_to_back_wr: got %0d required 0", dbl_wr); end
   endtask

   task automatic test_restart_zero();
      clear_mon();
      pulse_start();
      checks++; if (bus.cpu_hold !== 1'b1) begin errors++; $display("FAIL restart cpu_hold_after_start: got %b required 1", bus.cpu_hold); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL restart done_after_start: got %b required 0", bus.done); end
      // Start while busy must be ignored (it would otherwise clear the header).
      pulse_start();
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(8'h00, 0);
`endif
      repeat (3) @(negedge clk);
      checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL restart done: got %b required 1", bus.done); end
      checks++; if (bus.cpu_hold !== 1'b0) begin errors++; $display("FAIL restart cpu_hold: got %b required 0", bus.cpu_hold); end
      checks++; if (wa.size() !== 0) begin errors++; $display("FAIL restart write_count: got %0d required 0", wa.size()); end
   endtask

   task automatic test_reset_midload();
      clear_mon();
      pulse_start();
      send_byte(img[0], 0);
      send_byte(img[1], 0);
      for (int i = 2; i < 7; i++) send_byte(img[i], 0);
      // Assert reset between clock edges to see the asynchronous response.
      #2 reset = 1'b1;
      #1;
      test_reset();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      clear_mon();
      pulse_start();
      send_image(0);
      repeat (3) @(negedge clk);
      check_two_words("after_reset");
      checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL after_reset done: got %b required 1", bus.done); end
   endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
   task automatic test_checksum_bad();
      clear_mon();
      pulse_start();
      for (int i = 0; i < 10; i++) send_byte(img[i], 0);
      send_byte(good_csum + 8'd1, 0);
      repeat (3) @(negedge clk);
      check_two_words("csum_bad");
      checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL csum_bad err: got %b required 1", bus.err); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL csum_bad done: got %b required 0", bus.done); end
      checks++; if (bus.cpu_hold !== 1'b1) begin errors++; $display("FAIL csum_bad cpu_hold: got %b required 1", bus.cpu_hold); end
   endtask
`endif

   initial begin
      bus.start      = 1'b0;
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'h00;
      reset          = 1'b1;
      repeat (2) @(negedge clk);
      test_reset();
      reset = 1'b0;
      @(negedge clk);
      test_nominal();
      test_oversize();
      test_gapped();
      test_restart_zero();
      test_reset_midload();
`ifdef IMEM_LOADER_CHECKSUM_EN
      test_checksum_bad();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
